// File: rtl/seg_scan_driver.sv
// Binary-to-BCD converter (sequential shift-add-3) feeding a 3-digit multiplexed
// common-anode seven-segment display with optional leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] num_in,
  input  logic       num_valid,
  input  logic       enable,
  output logic       ready,
  output logic       busy,
  output logic [7:0] seg_n,
  output logic [2:0] dig_n
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state, state_next;
  logic [7:0]  bin;
  logic [11:0] work, work_adj;
  logic [2:0]  cnt;
  logic [3:0]  d_units, d_tens, d_hund;
  logic [PW-1:0] presc;
  logic [1:0]  idx;
  logic        accept;
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [2:0]  dig_next;
  logic [7:0]  seg_next;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 8'hC0;
      4'd1:    enc = 8'hF9;
      4'd2:    enc = 8'hA4;
      4'd3:    enc = 8'hB0;
      4'd4:    enc = 8'h99;
      4'd5:    enc = 8'h92;
      4'd6:    enc = 8'h82;
      4'd7:    enc = 8'hF8;
      4'd8:    enc = 8'h80;
      4'd9:    enc = 8'h90;
      default: enc = 8'hFF;
    endcase
  endfunction

  assign busy   = (state != IDLE);
  assign ready  = ~busy;
  assign accept = (state == IDLE) && num_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (num_valid) state_next = SHIFT;
      SHIFT:   if (cnt == 3'd7) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign work_adj = {adj3(work[11:8]), adj3(work[7:4]), adj3(work[3:0])};

  // Displayed digits are written only in COMMIT so the scan never sees a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin     <= '0;
      work    <= '0;
      cnt     <= '0;
      d_units <= '0;
      d_tens  <= '0;
      d_hund  <= '0;
    end else if (accept) begin
      bin  <= num_in;
      work <= '0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      work <= {work_adj[10:0], bin[7]};
      bin  <= {bin[6:0], 1'b0};
      cnt  <= cnt + 3'd1;
    end else if (state == COMMIT) begin
      d_units <= work[3:0];
      d_tens  <= work[7:4];
      d_hund  <= work[11:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PMAX) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    cur_digit = d_units;
    cur_blank = 1'b0;
    dig_next  = 3'b110;
    case (idx)
      2'd1: begin
        cur_digit = d_tens;
        cur_blank = BLANK_LZ && (d_hund == 4'd0) && (d_tens == 4'd0);
        dig_next  = 3'b101;
      end
      2'd2: begin
        cur_digit = d_hund;
        cur_blank = BLANK_LZ && (d_hund == 4'd0);
        dig_next  = 3'b011;
      end
      default: ;
    endcase
    seg_next = cur_blank ? 8'hFF : enc(cur_digit);
    if (!enable) begin
      dig_next = 3'b111;
      seg_next = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_n <= 3'b110;
      seg_n <= 8'hC0;
    end else begin
      dig_n <= dig_next;
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: two instances (leading-zero blanking on/off)
// share inputs; the scan position is predicted from a cycle count since reset.
module tb_seg_scan_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] num_in = '0;
  logic       num_valid = 1'b0;
  logic       enable = 1'b1;
  logic       ready, busy, ready0, busy0;
  logic [7:0] seg_n, seg_n0;
  logic [2:0] dig_n, dig_n0;

  int checks = 0;
  int failures = 0;
  int cyc;
  int bcnt;
  bit slot_ok;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .num_valid(num_valid), .enable(enable),
    .ready(ready), .busy(busy), .seg_n(seg_n), .dig_n(dig_n)
  );

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .num_valid(num_valid), .enable(enable),
    .ready(ready0), .busy(busy0), .seg_n(seg_n0), .dig_n(dig_n0)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Output after edge c reflects the scan index held before that edge.
  function automatic logic [2:0] exp_dig(input int c);
    int i;
    if (c == 0) return 3'b110;
    i = ((c - 1) / SD) % 3;
    case (i)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic wait_slot(input bit alt, input logic [2:0] d);
    slot_ok = 1'b0;
    for (int i = 0; i < 4 * SD && !slot_ok; i++) begin
      @(negedge clk);
      if ((alt ? dig_n0 : dig_n) === d) slot_ok = 1'b1;
    end
  endtask

  task automatic check_slot(input bit alt, input logic [2:0] d, input logic [7:0] exp, input string name);
    logic [7:0] s;
    wait_slot(alt, d);
    s = alt ? seg_n0 : seg_n;
    checks++;
    if (!slot_ok) begin
      failures++;
      $display("FAIL %s: digit select %b never seen, required within %0d cycles", name, d, 4 * SD);
    end else if (s !== exp) begin
      failures++;
      $display("FAIL %s: seg_n=%h required %h", name, s, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    num_in = v;
    num_valid = 1'b1;
    @(negedge clk);
    num_valid = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      bcnt++;
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] es;
    rst_n = 1'b0;
    enable = 1'b1;
    num_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: busy=%b ready=%b required busy=0 ready=1", busy, ready);
    end
    checks++;
    if (dig_n !== 3'b110 || seg_n !== 8'hC0) begin
      failures++;
      $display("FAIL reset_outputs: dig_n=%b seg_n=%h required 110 C0", dig_n, seg_n);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      es = (exp_dig(cyc) == 3'b110) ? 8'hC0 : 8'hFF;
      checks++;
      if (dig_n !== exp_dig(cyc) || seg_n !== es) begin
        failures++;
        $display("FAIL reset_scan[%0d]: dig_n=%b seg_n=%h required %b %h", k, dig_n, seg_n, exp_dig(cyc), es);
      end
    end
  endtask

  task automatic test_load_29;
    load(8'd29);
    checks++;
    if (bcnt != 9) begin
      failures++;
      $display("FAIL busy_len_29: busy cycles=%0d required 9", bcnt);
    end
    check_slot(1'b0, 3'b110, 8'h90, "29_units");
    check_slot(1'b0, 3'b101, 8'hA4, "29_tens");
    check_slot(1'b0, 3'b011, 8'hFF, "29_hund");
  endtask

  task automatic test_load_255_0;
    load(8'd255);
    check_slot(1'b0, 3'b110, 8'h92, "255_units");
    check_slot(1'b0, 3'b101, 8'h92, "255_tens");
    check_slot(1'b0, 3'b011, 8'hA4, "255_hund");
    load(8'd0);
    check_slot(1'b0, 3'b110, 8'hC0, "0_units");
    check_slot(1'b0, 3'b101, 8'hFF, "0_tens");
    check_slot(1'b0, 3'b011, 8'hFF, "0_hund");
    check_slot(1'b1, 3'b110, 8'hC0, "0_units_nolz");
    check_slot(1'b1, 3'b101, 8'hC0, "0_tens_nolz");
    check_slot(1'b1, 3'b011, 8'hC0, "0_hund_nolz");
  endtask

  task automatic test_back_to_back;
    // Pass A: 30 accepted, 99 pulses at N+2 and N+9 must be dropped.
    @(negedge clk);
    num_in = 8'd30; num_valid = 1'b1;
    @(negedge clk);                        // after N
    num_valid = 1'b0;
    bcnt = 1;
    @(negedge clk);                        // after N+1
    num_in = 8'd99; num_valid = 1'b1;
    @(negedge clk);                        // after N+2
    num_valid = 1'b0;
    bcnt += 2;
    repeat (6) @(negedge clk);             // after N+8
    bcnt += busy ? 6 : 0;
    num_valid = 1'b1;
    @(negedge clk);                        // after N+9
    num_valid = 1'b0;
    checks++;
    if (bcnt != 9 || busy !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore_a: busy=%b ready=%b cnt=%0d required busy=0 ready=1 cnt=9", busy, ready, bcnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL edge_valid_dropped: busy=%b required 0", busy);
    end
    check_slot(1'b0, 3'b110, 8'hC0, "30_units");
    check_slot(1'b0, 3'b101, 8'hB0, "30_tens");
    check_slot(1'b0, 3'b011, 8'hFF, "30_hund");
    // Pass B: 99 held from the busy-clearing edge is taken one edge later.
    @(negedge clk);
    num_in = 8'd30; num_valid = 1'b1;
    @(negedge clk);                        // after N
    num_valid = 1'b0;
    repeat (8) @(negedge clk);             // after N+8
    num_in = 8'd99; num_valid = 1'b1;
    @(negedge clk);                        // after N+9
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_edge_ignore: busy=%b required 0", busy);
    end
    @(negedge clk);                        // after N+10
    num_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_after_clear: busy=%b required 1", busy);
    end
    repeat (12) @(negedge clk);
    check_slot(1'b0, 3'b110, 8'h90, "99_units");
    check_slot(1'b0, 3'b101, 8'h90, "99_tens");
    check_slot(1'b0, 3'b011, 8'hFF, "99_hund");
  endtask

  task automatic test_enable;
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (dig_n !== 3'b111 || seg_n !== 8'hFF || dig_n0 !== 3'b111) begin
        failures++;
        $display("FAIL enable_dark[%0d]: dig_n=%b seg_n=%h dig_n0=%b required 111 FF 111", k, dig_n, seg_n, dig_n0);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (dig_n !== exp_dig(cyc)) begin
      failures++;
      $display("FAIL enable_resume: dig_n=%b required %b", dig_n, exp_dig(cyc));
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    num_in = 8'd128; num_valid = 1'b1;
    @(negedge clk);                        // after N
    num_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1 || dig_n !== 3'b110 || seg_n !== 8'hC0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b ready=%b dig_n=%b seg_n=%h required 0 1 110 C0", busy, ready, dig_n, seg_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_slot(1'b0, 3'b110, 8'hC0, "mid_reset_units");
    check_slot(1'b1, 3'b011, 8'hC0, "mid_reset_hund_nolz");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_busy: busy=%b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_29();
    test_load_255_0();
    test_back_to_back();
    test_enable();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
